// File: rtl/cell_draw_queue.sv
// cell_draw_queue: buffers changed grid cells and issues them as tile-redraw commands over valid/ready
module cell_draw_queue #(
  parameter int          DEPTH        = 8,
  parameter int          CELL_PX      = 20,
  parameter logic [15:0] COLOR_EMPTY  = 16'h0000,
  parameter logic [15:0] COLOR_HEAD   = 16'h07E0,
  parameter logic [15:0] COLOR_BODY   = 16'h03E0,
  parameter logic [15:0] COLOR_APPLE  = 16'hF800,
  parameter logic [15:0] COLOR_BORDER = 16'hFFFF
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         enable,
  input  logic                         diff,
  input  logic [2:0]                   obj_code,
  input  logic [3:0]                   x,
  input  logic [3:0]                   y,
  input  logic                         cmd_ready,
  output logic                         cmd_valid,
  output logic [8:0]                   x0,
  output logic [8:0]                   x1,
  output logic [8:0]                   y0,
  output logic [8:0]                   y1,
  output logic [15:0]                  color,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic {EMPTY, VALID} state_t;
  state_t state;
  logic [10:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_req, push, pop;
  logic [10:0] head;
  assign push_req = diff & enable & (y <= 4'd11);
  assign push     = push_req && (count < FULL);
  assign pop      = (count != '0) && (state == EMPTY || cmd_ready);
  assign head     = mem[rd_ptr];
  function automatic logic [8:0] px(input logic [3:0] c);
    return 9'(c) * 9'(CELL_PX);
  endfunction
  function automatic logic [15:0] code_color(input logic [2:0] code);
    case (code)
      3'b001:  return COLOR_HEAD;
      3'b010:  return COLOR_BODY;
      3'b011:  return COLOR_APPLE;
      3'b100:  return COLOR_BORDER;
      default: return COLOR_EMPTY;
    endcase
  endfunction
  // storage carries no reset; pointers and count alone define validity
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {x, y, obj_code};
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= EMPTY;
      cmd_valid <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      x0        <= '0;
      x1        <= '0;
      y0        <= '0;
      y1        <= '0;
      color     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (push_req && !push) overflow <= 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        state     <= VALID;
        cmd_valid <= 1'b1;
        x0        <= px(head[10:7]);
        x1        <= px(head[10:7]) + 9'(CELL_PX - 1);
        y0        <= px(head[6:3]);
        y1        <= px(head[6:3]) + 9'(CELL_PX - 1);
        color     <= code_color(head[2:0]);
      end else if (state == VALID && cmd_ready) begin
        state     <= EMPTY;
        cmd_valid <= 1'b0;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_cell_draw_queue.sv
// tb_cell_draw_queue: vector table, corner-case sequences and randomized run against a queue-based model
module tb_cell_draw_queue;
  localparam int DEPTH = 8;
  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;
  logic nrst, enable, diff, cmd_ready, cmd_valid, overflow;
  logic [2:0] obj_code;
  logic [3:0] x, y, count;
  logic [8:0] x0, x1, y0, y1;
  logic [15:0] color;
  int n_checks = 0, n_fail = 0;

  cell_draw_queue dut (
    .clk(tb_clk), .nrst(nrst), .enable(enable), .diff(diff), .obj_code(obj_code),
    .x(x), .y(y), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .x0(x0), .x1(x1),
    .y0(y0), .y1(y1), .color(color), .count(count), .overflow(overflow)
  );

  typedef struct { logic [3:0] cx, cy; logic [2:0] ob; } cell_t;
  cell_t q[$];
  logic m_valid, m_ovf;
  logic [8:0] m_x0, m_x1, m_y0, m_y1;
  logic [15:0] m_color;
  logic [15:0] palette [8] = '{16'h0000, 16'h07E0, 16'h03E0, 16'hF800, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};

  function automatic logic [57:0] mk(input logic v, input logic [3:0] c, input logic o,
                                     input logic [8:0] a, b, d, e, input logic [15:0] col);
    return {v, c, o, a, b, d, e, col};
  endfunction

  function automatic logic [57:0] dut_bus();
    return {cmd_valid, count, overflow, x0, x1, y0, y1, color};
  endfunction

  function automatic logic [57:0] model_bus();
    return {m_valid, 4'(q.size()), m_ovf, m_x0, m_x1, m_y0, m_y1, m_color};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Queue semantics: pop decision sees the pre-edge contents, then the new cell is appended
  task automatic model_step();
    if (!nrst) begin
      q.delete();
      m_valid = 0; m_ovf = 0;
      m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0; m_color = 0;
    end else begin
      bit req, dp;
      cell_t nc, c;
      req = diff && enable && (y < 12);
      dp  = req && (q.size() < DEPTH);
      nc  = '{x, y, obj_code};
      if (req && !dp) m_ovf = 1;
      if (q.size() > 0 && (!m_valid || cmd_ready)) begin
        c = q.pop_front();
        m_valid = 1;
        m_x0 = 9'(c.cx * 20); m_x1 = 9'(c.cx * 20 + 19);
        m_y0 = 9'(c.cy * 20); m_y1 = 9'(c.cy * 20 + 19);
        m_color = palette[c.ob];
      end else if (m_valid && cmd_ready) m_valid = 0;
      if (dp) q.push_back(nc);
    end
  endtask

  task automatic tick(input logic rn, en, df, input logic [2:0] ob, input logic [3:0] cx, cy, input logic rd);
    nrst = rn; enable = en; diff = df; obj_code = ob; x = cx; y = cy; cmd_ready = rd;
    @(posedge tb_clk);
    model_step();
    #1;
    chk("model", 64'(dut_bus()), 64'(model_bus()));
  endtask

  typedef struct { logic rn, en, df; logic [2:0] ob; logic [3:0] cx, cy; logic rd; logic [57:0] exp; } vec_t;
  vec_t vecs[$];

  initial begin
    logic [8:0] got[$];
    logic [51:0] cmds[$];
    logic [51:0] exp_cmds[3];
    nrst = 0; enable = 0; diff = 0; obj_code = 0; x = 0; y = 0; cmd_ready = 0;

    vecs = '{
      '{0,0,0,3'd0,4'd0, 4'd0, 1, mk(0,0,0,  0,  0,  0,  0,16'h0000)},
      '{1,1,1,3'd1,4'd3, 4'd2, 1, mk(0,1,0,  0,  0,  0,  0,16'h0000)},
      '{1,1,0,3'd0,4'd0, 4'd0, 1, mk(1,0,0, 60, 79, 40, 59,16'h07E0)},
      '{1,1,0,3'd0,4'd0, 4'd0, 1, mk(0,0,0, 60, 79, 40, 59,16'h07E0)},
      '{1,0,1,3'd2,4'd5, 4'd5, 1, mk(0,0,0, 60, 79, 40, 59,16'h07E0)},
      '{1,1,1,3'd3,4'd1, 4'd12,1, mk(0,0,0, 60, 79, 40, 59,16'h07E0)},
      '{1,1,1,3'd6,4'd15,4'd11,1, mk(0,1,0, 60, 79, 40, 59,16'h07E0)},
      '{1,1,0,3'd0,4'd0, 4'd0, 1, mk(1,0,0,300,319,220,239,16'h0000)},
      '{1,1,0,3'd0,4'd0, 4'd0, 1, mk(0,0,0,300,319,220,239,16'h0000)},
      '{1,1,1,3'd4,4'd0, 4'd0, 1, mk(0,1,0,300,319,220,239,16'h0000)},
      '{1,1,0,3'd0,4'd0, 4'd0, 1, mk(1,0,0,  0, 19,  0, 19,16'hFFFF)},
      '{1,1,0,3'd0,4'd0, 4'd0, 1, mk(0,0,0,  0, 19,  0, 19,16'hFFFF)}
    };
    foreach (vecs[i]) begin
      tick(vecs[i].rn, vecs[i].en, vecs[i].df, vecs[i].ob, vecs[i].cx, vecs[i].cy, vecs[i].rd);
      chk($sformatf("vec%0d", i), 64'(dut_bus()), 64'(vecs[i].exp));
    end

    // Backpressure: 10 pushes into a stalled sink, then drain
    tick(0,0,0,0,0,0,0);
    for (int i = 0; i < 10; i++) tick(1, 1, 1, 3'(i % 5), 4'(i + 1), 4'(i), 0);
    chk("bp_count", 64'(count), 64'd8);
    chk("bp_ovf", 64'(overflow), 64'd1);
    chk("bp_head", 64'({cmd_valid, x0, y0}), 64'({1'b1, 9'd20, 9'd0}));
    for (int i = 0; i < 14; i++) begin
      if (cmd_valid) got.push_back(x0);
      tick(1, 1, 0, 0, 0, 0, 1);
    end
    chk("bp_drained", 64'(got.size()), 64'd9);
    foreach (got[i]) chk($sformatf("bp_order%0d", i), 64'(got[i]), 64'((i + 1) * 20));

    // Reset while busy and overflowed
    for (int i = 0; i < 6; i++) tick(1, 1, 1, 3'd1, 4'(i), 4'(i), 0);
    chk("rst_pre", 64'({cmd_valid, count, overflow}), 64'({1'b1, 4'd5, 1'b1}));
    tick(0, 1, 1, 3'd1, 4'd9, 4'd9, 0);
    chk("rst_zero", 64'(dut_bus()), 64'd0);
    tick(1, 1, 1, 3'd2, 4'd7, 4'd3, 1);
    tick(1, 1, 0, 0, 0, 0, 1);
    chk("rst_restart", 64'(dut_bus()), 64'(mk(1,0,0,140,159,60,79,16'h03E0)));

    // Same-cycle push and pop at count 3
    tick(0,0,0,0,0,0,0);
    for (int i = 1; i <= 4; i++) tick(1, 1, 1, 3'd3, 4'(i), 4'd1, 0);
    chk("sc_pre", 64'({cmd_valid, count, x0}), 64'({1'b1, 4'd3, 9'd20}));
    tick(1, 1, 1, 3'd3, 4'd5, 4'd1, 1);
    chk("sc_post", 64'({cmd_valid, count, x0}), 64'({1'b1, 4'd3, 9'd40}));

    // Raster scan with three changed cells
    tick(0,0,0,0,0,0,1);
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 16; c++) begin
        logic hit;
        logic [2:0] ob;
        hit = (c == 2 && r == 1) || (c == 0 && r == 6) || (c == 15 && r == 11);
        ob = (c == 2) ? 3'd3 : (c == 0) ? 3'd2 : (c == 15) ? 3'd1 : 3'd0;
        if (cmd_valid) cmds.push_back({x0, x1, y0, y1, color});
        tick(1, 1, hit, ob, 4'(c), 4'(r), 1);
      end
    for (int i = 0; i < 4; i++) begin
      if (cmd_valid) cmds.push_back({x0, x1, y0, y1, color});
      tick(1, 1, 0, 0, 0, 0, 1);
    end
    exp_cmds = '{{9'd40, 9'd59, 9'd20, 9'd39, 16'hF800},
                 {9'd0, 9'd19, 9'd120, 9'd139, 16'h03E0},
                 {9'd300, 9'd319, 9'd220, 9'd239, 16'h07E0}};
    chk("scan_n", 64'(cmds.size()), 64'd3);
    foreach (cmds[i]) if (i < 3) chk($sformatf("scan_cmd%0d", i), 64'(cmds[i]), 64'(exp_cmds[i]));

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++)
      tick($urandom_range(0, 60) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 13)),
           $urandom_range(0, 2) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
